// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the CPU/DMA unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned STAT_W     = 16;
  // Wide enough for MAX_WAIT up to 15.
  localparam int unsigned WAIT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    ID_CPU = 1'b0,
    ID_DMA = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory access channel: req/gnt handshake plus read return.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arb_stats.sv
// Saturating grant/conflict counters for the memory port arbiter.
// Present only when ARB_STATS_EN is defined.
`ifdef ARB_STATS_EN
module mem_arb_stats
  import mem_arb_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              cpu_gnt,
  input  logic              dma_gnt,
  input  logic              conflict,
  output logic [STAT_W-1:0] stat_cpu_cnt,
  output logic [STAT_W-1:0] stat_dma_cnt,
  output logic [STAT_W-1:0] stat_conflict_cnt
);

  // Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      stat_cpu_cnt      <= '0;
      stat_dma_cnt      <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (cpu_gnt && !(&stat_cpu_cnt))
        stat_cpu_cnt <= stat_cpu_cnt + STAT_W'(1);
      if (dma_gnt && !(&stat_dma_cnt))
        stat_dma_cnt <= stat_dma_cnt + STAT_W'(1);
      if (conflict && !(&stat_conflict_cnt))
        stat_conflict_cnt <= stat_conflict_cnt + STAT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the CPU and a DMA/IO requester.
// CPU has priority; DMA wins after MAX_WAIT consecutive lost arbitrations.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               CLK,
  input  logic               Reset_n,
  mem_port_arbiter_if.slave  cpu,
  mem_port_arbiter_if.slave  dma,
  output logic               cpu_stall,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
`ifdef ARB_STATS_EN
  output logic [STAT_W-1:0]  stat_cpu_cnt,
  output logic [STAT_W-1:0]  stat_dma_cnt,
  output logic [STAT_W-1:0]  stat_conflict_cnt,
`endif
  input  logic [DATA_W-1:0]  mem_rdata
);

  arb_state_e        state_q, state_d;
  req_id_e           win_q, win_d;
  logic              we_q, we_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              mem_we_d;
  logic              cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic              dma_wins_c;

  // DMA wins when alone, or when the CPU has starved it MAX_WAIT times.
  assign dma_wins_c = dma.req & (~cpu.req | (wait_q == WAIT_W'(MAX_WAIT)));

  assign cpu.gnt    = cpu_gnt_q;
  assign cpu.rvalid = cpu_rvalid_q;
  assign cpu.rdata  = cpu_rdata_q;
  assign dma.gnt    = dma_gnt_q;
  assign dma.rvalid = dma_rvalid_q;
  assign dma.rdata  = dma_rdata_q;

  // Hold the CPU control FSM until its write is granted or its read returns.
  assign cpu_stall = cpu.req & ~(cpu_gnt_q & cpu.we) & ~cpu_rvalid_q;

  // FSM state register.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state, arbitration and next values of the port registers.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    we_d         = we_q;
    wait_d       = wait_q;
    addr_d       = mem_addr;
    wdata_d      = mem_wdata;
    mem_we_d     = 1'b0;
    cpu_gnt_d    = 1'b0;
    dma_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu.req || dma.req) begin
          state_d = ST_ACCESS;
          if (dma_wins_c) begin
            win_d   = ID_DMA;
            we_d    = dma.we;
            addr_d  = dma.addr;
            wdata_d = dma.wdata;
          end else begin
            win_d   = ID_CPU;
            we_d    = cpu.we;
            addr_d  = cpu.addr;
            wdata_d = cpu.wdata;
          end
        end
        if (!dma.req || dma_wins_c)
          wait_d = '0;
        else if (cpu.req && (wait_q != WAIT_W'(MAX_WAIT)))
          wait_d = wait_q + WAIT_W'(1);
      end
      ST_ACCESS: begin
        mem_we_d  = we_q;
        cpu_gnt_d = (win_q == ID_CPU);
        dma_gnt_d = (win_q == ID_DMA);
        state_d   = we_q ? ST_IDLE : ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (win_q == ID_CPU) begin
          cpu_rdata_d  = mem_rdata;
          cpu_rvalid_d = 1'b1;
        end else begin
          dma_rdata_d  = mem_rdata;
          dma_rvalid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered memory port, handshake outputs and per-requester read data.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      win_q        <= ID_CPU;
      we_q         <= 1'b0;
      wait_q       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      win_q        <= win_d;
      we_q         <= we_d;
      wait_q       <= wait_d;
      mem_addr     <= addr_d;
      mem_wdata    <= wdata_d;
      mem_we       <= mem_we_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dma_gnt_q    <= dma_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

`ifdef ARB_STATS_EN
  logic conflict_c;

  // A conflict is an arbitration cycle with both requesters asking.
  assign conflict_c = (state_q == ST_IDLE) & cpu.req & dma.req;

  mem_arb_stats u_stats (
    .CLK               (CLK),
    .Reset_n           (Reset_n),
    .cpu_gnt           (cpu_gnt_q),
    .dma_gnt           (dma_gnt_q),
    .conflict          (conflict_c),
    .stat_cpu_cnt      (stat_cpu_cnt),
    .stat_dma_cnt      (stat_dma_cnt),
    .stat_conflict_cnt (stat_conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (stats checked when ARB_STATS_EN is defined).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          CLK = 1'b0;
  logic          Reset_n = 1'b0;
  logic          cpu_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_cpu_cnt, stat_dma_cnt, stat_conflict_cnt;
`endif

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dma_bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .CLK               (CLK),
    .Reset_n           (Reset_n),
    .cpu               (cpu_bus),
    .dma               (dma_bus),
    .cpu_stall         (cpu_stall),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_we            (mem_we),
`ifdef ARB_STATS_EN
    .stat_cpu_cnt      (stat_cpu_cnt),
    .stat_dma_cnt      (stat_dma_cnt),
    .stat_conflict_cnt (stat_conflict_cnt),
`endif
    .mem_rdata         (mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory: one-cycle read latency, write on mem_we.
  logic [DW-1:0] mem [0:65535];
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic dma_write(input logic [15:0] a, input logic [15:0] d);
    dma_bus.req = 1'b1; dma_bus.we = 1'b1; dma_bus.addr = a; dma_bus.wdata = d;
    tick();
    chk("wr_we_early", 16'(mem_we), 16'h0);
    chk("wr_addr_latched", mem_addr, a);
    tick();
    chk("wr_mem_we", 16'(mem_we), 16'h1);
    chk("wr_dma_gnt", 16'(dma_bus.gnt), 16'h1);
    chk("wr_cpu_gnt", 16'(cpu_bus.gnt), 16'h0);
    chk("wr_mem_wdata", mem_wdata, d);
    dma_bus.req = 1'b0;
    tick();
    chk("wr_we_pulse", 16'(mem_we), 16'h0);
    chk("wr_gnt_pulse", 16'(dma_bus.gnt), 16'h0);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [15:0] exp);
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = a; cpu_bus.wdata = 16'h0;
    #1;
    chk("rd_stall_req", 16'(cpu_stall), 16'h1);
    tick();
    chk("rd_gnt_early", 16'(cpu_bus.gnt), 16'h0);
    tick();
    chk("rd_gnt", 16'(cpu_bus.gnt), 16'h1);
    chk("rd_stall_gnt", 16'(cpu_stall), 16'h1);
    chk("rd_no_we", 16'(mem_we), 16'h0);
    tick();
    chk("rd_rvalid", 16'(cpu_bus.rvalid), 16'h1);
    chk("rd_rdata", cpu_bus.rdata, exp);
    chk("rd_stall_done", 16'(cpu_stall), 16'h0);
    chk("rd_dma_rvalid", 16'(dma_bus.rvalid), 16'h0);
    cpu_bus.req = 1'b0;
    tick();
    chk("rd_rvalid_pulse", 16'(cpu_bus.rvalid), 16'h0);
    chk("rd_rdata_hold", cpu_bus.rdata, exp);
  endtask

  // Both requesters write; each drops its request on its own grant.
  task automatic serve(input logic c, input logic d);
    cpu_bus.req = c; cpu_bus.we = 1'b1; cpu_bus.addr = 16'h0300; cpu_bus.wdata = 16'h0C0C;
    dma_bus.req = d; dma_bus.we = 1'b1; dma_bus.addr = 16'h0310; dma_bus.wdata = 16'h0D0D;
    for (int c2 = 0; c2 < 20; c2++) begin
      tick();
      if (cpu_bus.gnt) cpu_bus.req = 1'b0;
      if (dma_bus.gnt) dma_bus.req = 1'b0;
      if (!cpu_bus.req && !dma_bus.req) break;
    end
    chk("serve_done", 16'(cpu_bus.req | dma_bus.req), 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] winners [10];
    int got;
    int cpu_rv, dma_rv;

    cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; cpu_bus.addr = '0; cpu_bus.wdata = '0;
    dma_bus.req = 1'b0; dma_bus.we = 1'b0; dma_bus.addr = '0; dma_bus.wdata = '0;
    repeat (2) tick();
    Reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_cpu_gnt", 16'(cpu_bus.gnt), 16'h0);
    chk("rst_dma_gnt", 16'(dma_bus.gnt), 16'h0);
    chk("rst_cpu_rdata", cpu_bus.rdata, 16'h0);
    chk("rst_dma_rdata", dma_bus.rdata, 16'h0);
    chk("rst_stall", 16'(cpu_stall), 16'h0);

    // DMA writes with CPU idle (also loads memory for later reads)
    dma_write(16'h0200, 16'h1234);
    dma_write(16'h0010, 16'hBEEF);

    // CPU read
    cpu_read(16'h0010, 16'hBEEF);

    // Continuous contention: CPU x4 then DMA, repeating
    for (int i = 0; i < 10; i++) winners[i] = 16'hFFFF;
    got = 0;
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b1; cpu_bus.addr = 16'h0080; cpu_bus.wdata = 16'h1111;
    dma_bus.req = 1'b1; dma_bus.we = 1'b1; dma_bus.addr = 16'h0090; dma_bus.wdata = 16'h2222;
    for (int c = 0; c < 60 && got < 10; c++) begin
      tick();
      if (cpu_bus.gnt || dma_bus.gnt) begin
        chk("arb_one_hot", 16'(cpu_bus.gnt & dma_bus.gnt), 16'h0);
        winners[got] = 16'(dma_bus.gnt);
        got++;
      end
    end
    cpu_bus.req = 1'b0;
    dma_bus.req = 1'b0;
    tick();
    chk("arb_count", 16'(got), 16'd10);
    for (int i = 0; i < 10; i++)
      chk("arb_order", winners[i], (i % 5 == 4) ? 16'h1 : 16'h0);

    // Simultaneous reads: CPU first, DMA next, data routed to owner only
    cpu_rv = 0; dma_rv = 0;
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 16'h0010;
    dma_bus.req = 1'b1; dma_bus.we = 1'b0; dma_bus.addr = 16'h0200;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (cpu_bus.rvalid) cpu_rv++;
      if (dma_bus.rvalid) dma_rv++;
      if (c == 2) chk("dual_cpu_gnt", 16'(cpu_bus.gnt), 16'h1);
      if (c == 3) begin
        chk("dual_cpu_rvalid", 16'(cpu_bus.rvalid), 16'h1);
        chk("dual_cpu_rdata", cpu_bus.rdata, 16'hBEEF);
        chk("dual_dma_rdata_untouched", dma_bus.rdata, 16'h0);
        cpu_bus.req = 1'b0;
      end
      if (c == 5) chk("dual_dma_gnt", 16'(dma_bus.gnt), 16'h1);
      if (c == 6) begin
        chk("dual_dma_rvalid", 16'(dma_bus.rvalid), 16'h1);
        chk("dual_dma_rdata", dma_bus.rdata, 16'h1234);
        chk("dual_cpu_rdata_hold", cpu_bus.rdata, 16'hBEEF);
        dma_bus.req = 1'b0;
      end
    end
    chk("dual_cpu_rv_count", 16'(cpu_rv), 16'd1);
    chk("dual_dma_rv_count", 16'(dma_rv), 16'd1);

    // Reset during RD_DATA of a CPU read
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 16'h0200;
    tick();
    tick();
    chk("rstrd_gnt", 16'(cpu_bus.gnt), 16'h1);
    Reset_n = 1'b0;
    cpu_bus.req = 1'b0;
    #1;
    chk("rstrd_gnt_clr", 16'(cpu_bus.gnt), 16'h0);
    chk("rstrd_addr_clr", mem_addr, 16'h0);
    chk("rstrd_rdata_clr", cpu_bus.rdata, 16'h0);
    chk("rstrd_stall", 16'(cpu_stall), 16'h0);
    tick();
    chk("rstrd_no_rvalid", 16'(cpu_bus.rvalid), 16'h0);
    Reset_n = 1'b1;
    tick();
    chk("rstrd_no_rvalid2", 16'(cpu_bus.rvalid), 16'h0);
    chk("rstrd_rdata_zero", cpu_bus.rdata, 16'h0);
    cpu_read(16'h0010, 16'hBEEF);

`ifdef ARB_STATS_EN
    // 3 CPU grants, 2 DMA grants, 2 conflict cycles
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    serve(1'b1, 1'b1);
    serve(1'b1, 1'b1);
    serve(1'b1, 1'b0);
    tick();
    chk("stat_cpu", stat_cpu_cnt, 16'd3);
    chk("stat_dma", stat_dma_cnt, 16'd2);
    chk("stat_conflict", stat_conflict_cnt, 16'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
